// File: rtl/ccff_pkg.sv
// ccff_pkg: shared state type, CRC constants and CRC-16 step for the ccff chain loader
package ccff_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, FINISH} ccff_state_e;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b,
                                             input logic [15:0] poly = CRC_POLY);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? poly : 16'h0000);
  endfunction
endpackage

// File: rtl/ccff_word_serializer.sv
// ccff_word_serializer: holds one bitstream word and shifts it out MSB-first with a bit counter
module ccff_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [WORD_W-1:0] data,
  output logic              msb,
  output logic              last,
  output logic              empty
);
  localparam int BW = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] word;
  logic [BW-1:0] bit_in_word;
  always_ff @(posedge prog_clk)
    if (!prog_reset_n || clear) begin
      word <= '0;
      bit_in_word <= '0;
    end else if (load) begin
      word <= data;
      bit_in_word <= BW'(WORD_W);
    end else if (shift) begin
      word <= word << 1;
      bit_in_word <= bit_in_word - 1'b1;
    end
  assign msb = word[WORD_W-1];
  assign last = bit_in_word == BW'(1);
  assign empty = bit_in_word == '0;
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: programs a ccff shift chain from host words; define CCFF_READBACK_EN for CRC readback verify
module ccff_chain_loader #(
  parameter int WORD_W = 32,
  parameter int MAX_LEN = 4096,
  parameter logic [15:0] CRC_POLY = 16'h1021,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [LW-1:0]     chain_len,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import ccff_pkg::*;
  ccff_state_e state;
  logic [LW-1:0] rem;
  logic ser_msb, ser_last, ser_empty;
  assign s_ready = state == FETCH;
  assign busy = state != IDLE;
  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .load         (s_ready && s_valid),
    .shift        (state == SHIFT),
    .clear        (state == SHIFT && rem == LW'(1)),
    .data         (s_data),
    .msb          (ser_msb),
    .last         (ser_last),
    .empty        (ser_empty)
  );
`ifdef CCFF_READBACK_EN
  logic [LW-1:0] len;
  logic [15:0] crc_w, crc_r;
  logic unused;
  assign unused = ser_empty;
  assign ccff_shift_en = state == SHIFT || state == VERIFY;
  assign ccff_head = state == VERIFY ? ccff_tail : ser_msb;
`else
  logic unused;
  assign unused = ^{ccff_tail, CRC_POLY, ser_empty};
  assign ccff_shift_en = state == SHIFT;
  assign ccff_head = ser_msb;
`endif
  always_ff @(posedge prog_clk)
    if (!prog_reset_n) begin
      state <= IDLE;
      rem <= '0;
      done <= 1'b0;
      error <= 1'b0;
`ifdef CCFF_READBACK_EN
      len <= '0;
      crc_w <= '0;
      crc_r <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (chain_len == '0) begin
            error <= 1'b1;
            done <= 1'b1;
          end else begin
            error <= 1'b0;
            rem <= chain_len;
            state <= FETCH;
`ifdef CCFF_READBACK_EN
            len <= chain_len;
            crc_w <= CRC_INIT;
            crc_r <= CRC_INIT;
`endif
          end
        end
        FETCH: if (s_valid) state <= SHIFT;
        SHIFT: begin
          rem <= rem - 1'b1;
`ifdef CCFF_READBACK_EN
          crc_w <= crc16_step(crc_w, ser_msb, CRC_POLY);
`endif
          if (rem == LW'(1)) begin
`ifdef CCFF_READBACK_EN
            state <= VERIFY;
            rem <= len;
`else
            state <= FINISH;
            done <= 1'b1;
`endif
          end else if (ser_last) state <= FETCH;
        end
`ifdef CCFF_READBACK_EN
        VERIFY: begin
          rem <= rem - 1'b1;
          crc_r <= crc16_step(crc_r, ccff_tail, CRC_POLY);
          if (rem == LW'(1)) begin
            state <= FINISH;
            done <= 1'b1;
            error <= crc_w != crc16_step(crc_r, ccff_tail, CRC_POLY);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: vector table, corner sequences and random runs against a chain/bitstream model
module tb_ccff_chain_loader;
  localparam int LW = $clog2(4096 + 1);
`ifdef CCFF_READBACK_EN
  localparam int RB = 2;
`else
  localparam int RB = 1;
`endif
  logic prog_clk = 1'b0, prog_reset_n, start, s_valid, s_ready, ccff_head, ccff_tail, ccff_shift_en;
  logic busy, done, error;
  logic [LW-1:0] chain_len;
  logic [31:0] s_data;
  logic [31:0] words[8];
  logic chain[128];
  logic head_log[512];
  int en_total = 0, done_total = 0, hs_total = 0, idle_total = 0;
  int cl = 1;
  bit stuck_on = 1'b0;
  int total = 0, bad = 0;
  typedef struct {
    int len; int stall; logic [31:0] w0; logic [31:0] w1; bit poke;
    int exp_en; int exp_hs; int exp_idle;
  } vec_t;
  vec_t vecs[7];
  ccff_chain_loader dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start), .chain_len(chain_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en), .busy(busy), .done(done), .error(error)
  );
  always #5 prog_clk = ~prog_clk;
  assign ccff_tail = chain[cl - 1];
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      en_total <= en_total + 1;
      head_log[en_total % 512] <= ccff_head;
      for (int i = 0; i < 128; i++)
        chain[i] <= (stuck_on && i == 3) ? 1'b0 : (i == 0 ? ccff_head : chain[i - 1]);
    end
    if (done) done_total <= done_total + 1;
    if (s_valid && s_ready) hs_total <= hs_total + 1;
    if (busy && !ccff_shift_en) idle_total <= idle_total + 1;
  end
  function automatic logic sbit(input int i);
    logic [31:0] w;
    w = words[i / 32];
    return w[31 - i % 32];
  endfunction
  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask
  task automatic run(input int len, input int stall, input bit poke, input bit stuck,
                     input int exp_en, input int exp_hs, input int exp_idle, input int exp_err);
    int e0, d0, h0, i0, st, rel, miss;
    e0 = en_total; d0 = done_total; h0 = hs_total; i0 = idle_total; st = stall;
    cl = len;
    stuck_on = stuck;
    @(negedge prog_clk);
    chain_len = LW'(len);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    for (int t = 0; t < 4000 && done_total == d0; t++) begin
      rel = hs_total - h0;
      s_valid = !(rel == 1 && st > 0);
      if (!s_valid && s_ready) st--;
      s_data = words[rel % 8];
      if (poke && t == 20) begin
        start = 1'b1;
        chain_len = LW'(5);
      end else start = 1'b0;
      @(negedge prog_clk);
    end
    start = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("en_cycles", en_total - e0, exp_en);
    check("words_taken", hs_total - h0, exp_hs);
    check("idle_cycles", idle_total - i0, exp_idle);
    check("done_pulses", done_total - d0, 1);
    check("error", int'(error), exp_err);
    check("idle_outputs", int'({busy, s_ready, ccff_shift_en}), 0);
    if (!stuck) begin
      miss = 0;
      for (int i = 0; i < exp_en; i++) if (head_log[(e0 + i) % 512] !== sbit(i % len)) miss++;
      check("head_seq", miss, 0);
      miss = 0;
      for (int k = 0; k < len; k++) if (chain[k] !== sbit(len - 1 - k)) miss++;
      check("chain_contents", miss, 0);
    end
  endtask
  initial begin
    int d0, h0, len, st, hs;
    vecs[0] = '{36, 0, 32'hA5A5_A5A5, 32'hF000_0000, 1'b0, 36, 2, 3};
    vecs[1] = '{36, 10, 32'hA5A5_A5A5, 32'hF000_0000, 1'b0, 36, 2, 13};
    vecs[2] = '{36, 0, 32'hA5A5_A5A5, 32'hF000_0000, 1'b1, 36, 2, 3};
    vecs[3] = '{32, 0, 32'h1234_5678, 32'h0000_0000, 1'b0, 32, 1, 2};
    vecs[4] = '{33, 0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 2, 3};
    vecs[5] = '{1, 0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1, 1, 2};
    vecs[6] = '{64, 3, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0, 64, 2, 6};
    for (int i = 0; i < 128; i++) chain[i] = 1'b0;
    for (int w = 0; w < 8; w++) words[w] = 32'h0;
    prog_reset_n = 1'b0; start = 1'b0; chain_len = '0; s_data = '0; s_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("reset_outputs", int'({s_ready, ccff_head, ccff_shift_en, busy, done, error}), 0);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    words[0] = 32'hFFFF_FFFF;
    cl = 36;
    chain_len = LW'(36); start = 1'b1; s_valid = 1'b1; s_data = words[0];
    @(negedge prog_clk);
    start = 1'b0;
    repeat (8) @(negedge prog_clk);
    check("mid_shift_enable", int'(ccff_shift_en), 1);
    d0 = done_total;
    prog_reset_n = 1'b0;
    repeat (3) @(negedge prog_clk);
    check("midreset_outputs", int'({s_ready, ccff_head, ccff_shift_en, busy, done, error}), 0);
    prog_reset_n = 1'b1;
    s_valid = 1'b0;
    repeat (5) @(negedge prog_clk);
    check("midreset_no_done", done_total - d0, 0);
    check("midreset_idle", int'(busy), 0);
    d0 = done_total; h0 = hs_total;
    s_valid = 1'b1;
    chain_len = '0; start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    check("zero_len_done", int'(done), 1);
    check("zero_len_error", int'(error), 1);
    check("zero_len_busy", int'(busy), 0);
    @(negedge prog_clk);
    check("zero_len_done_once", int'(done), 0);
    check("zero_len_error_sticky", int'(error), 1);
    repeat (3) @(negedge prog_clk);
    check("zero_len_no_handshake", hs_total - h0, 0);
    check("zero_len_done_count", done_total - d0, 1);
    s_valid = 1'b0;
    for (int v = 0; v < 7; v++) begin
      for (int w = 0; w < 8; w++) words[w] = 32'h0;
      words[0] = vecs[v].w0;
      words[1] = vecs[v].w1;
      run(vecs[v].len, vecs[v].stall, vecs[v].poke, 1'b0,
          vecs[v].exp_en * RB, vecs[v].exp_hs, vecs[v].exp_idle, 0);
    end
`ifdef CCFF_READBACK_EN
    words[0] = 32'hA5A5_A5A5;
    words[1] = 32'hF000_0000;
    run(36, 0, 1'b0, 1'b1, 72, 2, 3, 1);
    run(36, 0, 1'b0, 1'b0, 72, 2, 3, 0);
`endif
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, 100);
      st = $urandom_range(0, 3);
      for (int w = 0; w < 8; w++) words[w] = $urandom;
      hs = (len + 31) / 32;
      run(len, st, 1'b0, 1'b0, len * RB, hs, hs + (hs > 1 ? st : 0) + 1, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences configuration-chain programming for a tile column of routing blocks (connection/switch blocks whose mux SRAMs form one ccff_head→ccff_tail shift chain).
- Accepts bitstream words from the host over valid/ready and serializes them onto ccff_head, one bit per enabled prog_clk cycle.
- Drives the shift enable that qualifies the chain's clock, counts the programmed length and reports done or error.
- Sits between the bitstream DMA/host interface and the chain head of each column.

Parameters:
- WORD_W, 32, input word width in bits.
- MAX_LEN, 4096, maximum chain length in bits; the counter width is $clog2(MAX_LEN+1).
- CRC_POLY, 16'h1021, CRC-16 polynomial used by the readback feature.

Ports:
- prog_clk  in  1  programming clock; the only clock.
- prog_reset_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; starts programming. Ignored unless in IDLE.
- chain_len  in  $clog2(MAX_LEN+1)  bits to shift; sampled on start.
- s_data  in  WORD_W  bitstream word.
- s_valid  in  1  word valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- ccff_head  out  1  serial bit to chain head.
- ccff_tail  in  1  serial bit from chain tail.
- ccff_shift_en  out  1  chain clock-enable; the chain advances on prog_clk edges where it is 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky until the next start; set by zero length or readback mismatch.

Behaviour:
- Reset (prog_reset_n=0 at a prog_clk edge):
  - state=IDLE.
  - s_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, error=0.
  - Counters and CRC registers cleared.
  - Reset mid-shift aborts immediately; chain contents are undefined; no done is issued.
- States: IDLE, FETCH, SHIFT, VERIFY (feature only), FINISH.
- IDLE:
  - start with chain_len==0 → error=1, done pulse next cycle, stay IDLE.
  - start with chain_len>0 → latch len, clear error, go to FETCH.
- FETCH:
  - s_ready=1 and ccff_shift_en=0.
  - On handshake: load the word into the shift register, set bit_in_word=WORD_W, go to SHIFT.
  - s_valid low → stall indefinitely; the chain holds.
- SHIFT:
  - Each cycle: ccff_shift_en=1, ccff_head=word MSB (registered output), shift the word left, decrement bit_in_word and remaining.
  - remaining reaches 0 → go to FINISH (or VERIFY), discarding the unused LSBs of the final word.
  - bit_in_word reaches 0 with remaining>0 → go to FETCH.
  - No bubble-free prefetch: exactly one idle chain cycle per word boundary.
- Bit order: word 0 MSB enters the chain first and therefore ends nearest ccff_tail after len shifts.
- FINISH: one cycle; done=1; go to IDLE. s_ready=0 throughout FINISH and IDLE.
- ccff_shift_en is asserted only in SHIFT/VERIFY. The total count of enabled cycles equals len (or 2·len with the feature).
- start while busy: ignored, with no effect on counters.
- s_valid while not in FETCH: held off (s_ready=0); data is not consumed.

Optional Feature:
- Macro CCFF_READBACK_EN.
- With the macro:
  - A CRC-16 (CRC_POLY, init 16'hFFFF) accumulates every bit driven on ccff_head during SHIFT.
  - After SHIFT the block enters VERIFY for exactly len cycles.
  - VERIFY: ccff_shift_en=1, ccff_head=ccff_tail (recirculation, so the chain ends restored), and a second CRC accumulates ccff_tail.
  - At the end: CRCs differ → error=1. Then FINISH.
  - Net effect: the chain holds the programmed data, and done is delayed by len cycles.
- Without the macro: no VERIFY state, no CRC registers; ccff_tail is unused.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum typedef ccff_state_e;
  - the CRC_POLY and CRC_INIT constants;
  - a function crc16_step(crc, bit).
- One sub-module, ccff_word_serializer: word register, MSB-first shift, bit_in_word counter and empty flag. The FSM, length counter and CRC stay in the top.

Test Plan:
- Reset: hold prog_reset_n=0 for 3 cycles mid-SHIFT → all outputs 0, state IDLE, no done.
- chain_len=36, WORD_W=32, words 32'hA5A5_A5A5, 32'hF000_0000 →
  - exactly 36 ccff_shift_en cycles;
  - head sequence = 32 bits of A5A5A5A5 MSB-first, then 1,1,1,1;
  - one gap cycle after bit 32;
  - done pulse once.
- Backpressure: s_valid low for 10 cycles before word 2 → ccff_shift_en=0 throughout the stall; final chain model contents identical to the no-stall run.
- chain_len=0 start → error=1 and done the following cycle, s_ready never asserted. Start during busy → ignored.
- CCFF_READBACK_EN:
  - With a 36-bit chain model, len=36 → 72 enable cycles, error=0, chain restored.
  - Inject a stuck-at-0 chain bit → error=1 after the VERIFY pass.
